fifo_sram_reader: RTL

Read-side controller for the 16-bit SRAM FIFO. It watches the FIFO write strobe to track occupancy and issues single-cycle `rd` pulses whenever words are stored and local space is free. It captures `dout` after a fixed read latency and presents the words on a valid/ready stream to the downstream consumer. It sits next to the FIFO and replaces hand-driven read pulses with a flow-controlled drain path.

---
 rtl/fifo_sram_reader.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_sram_reader.sv
// Read-side drain controller for the 16-bit SRAM FIFO: tracks occupancy from the write strobe,
// issues rd pulses and streams words out. Optional macro: FIFO_RD_SPACING_EN (one idle cycle after each rd).
module fifo_sram_reader #(
  parameter int DW     = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_mon_i,
  output logic          rd_o,
  input  logic [DW-1:0] dout_i,
  output logic [DW-1:0] m_data_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          ovf_o
);

  localparam logic [0:0]  RD_IDLE = 1'b0;
  localparam logic [0:0]  RD_GAP  = 1'b1;
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);

  logic [AW:0]       level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [0:0]        rs_q, rs_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [DW-1:0]     buf_q [4];
  logic [1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        inflight;
  logic              wr_acc, push, pop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 3'(pipe_q[i]);
  end

  // Reads are budgeted against words already in flight so the 4-entry buffer can never overflow.
  assign rd_o   = (level_q != '0) && (({1'b0, inflight} + {1'b0, cnt_q}) < 4'd4) && (rs_q == RD_IDLE);
  assign push   = pipe_q[RD_LAT-1];
  assign pop    = m_valid_o && m_ready_i;
  assign wr_acc = wr_mon_i && ((level_q != FULL) || rd_o);

  always_comb begin
    level_d = level_q + (AW+1)'(wr_acc) - (AW+1)'(rd_o);
    ovf_d   = ovf_q | (wr_mon_i && (level_q == FULL) && !rd_o);
    pipe_d  = RD_LAT'({pipe_q, rd_o});
    wp_d    = wp_q + 2'(push);
    rp_d    = rp_q + 2'(pop);
    cnt_d   = cnt_q + 3'(push) - 3'(pop);
`ifdef FIFO_RD_SPACING_EN
    rs_d    = ((rs_q == RD_IDLE) && rd_o) ? RD_GAP : RD_IDLE;
`else
    rs_d    = RD_IDLE;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      rs_q    <= RD_IDLE;
      pipe_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      rs_q    <= rs_d;
      pipe_q  <= pipe_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the data buffer is reset on purpose so m_data reads zero straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
    end else if (push) begin
      buf_q[wp_q] <= dout_i;
    end
  end

  assign m_data_o  = buf_q[rp_q];
  assign m_valid_o = (cnt_q != '0);
  assign level_o   = level_q;
  assign empty_o   = (level_q == '0);
  assign ovf_o     = ovf_q;

endmodule
